requant_relu: RTL and testbench

- Downstream stage of the multiplier-accumulator: takes each finished accumulator word and produces one quantized activation.
- Datapath: bias add, round-half-up arithmetic right shift, optional ReLU, then saturation to a signed OUT_WIDTH activation.
- Two-stage pipeline with valid/ready on both sides. Feeds the activation buffer / next layer's MAC operand path.

---
 rtl/requant_pkg.sv | 28 ++
 rtl/requant_round_sat.sv | 47 ++++
 rtl/requant_relu.sv | 123 ++++++++++++
 tb/tb_requant_relu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared widths and range helpers for the requantize / ReLU / saturate stage.
package requant_pkg;

  localparam int DEF_ACC_WIDTH     = 10;
  localparam int DEF_BIAS_WIDTH    = 11;
  localparam int DEF_OUT_WIDTH     = 8;
  localparam int DEF_SHIFT_WIDTH   = 4;
  localparam int DEF_SAT_CNT_WIDTH = 16;

  // Width holding zero_ext(acc) + sign_ext(bias) without overflow.
  function automatic int sum_width(input int acc_w, input int bias_w);
    return (((acc_w + 1) > bias_w) ? (acc_w + 1) : bias_w) + 1;
  endfunction

  // Width for sum + rounding constant at the largest shift, plus a sign bit of headroom.
  function automatic int round_width(input int s_w, input int shift_w);
    return ((s_w > (1 << shift_w)) ? s_w : (1 << shift_w)) + 2;
  endfunction

  function automatic int out_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int out_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational stage-2 datapath: round-half-up shift, optional ReLU, signed clamp.
module requant_round_sat
  import requant_pkg::*;
#(
  parameter int S           = sum_width(DEF_ACC_WIDTH, DEF_BIAS_WIDTH),
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
  input  logic signed [S-1:0]           sum_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  input  logic                          relu_en_i,
  output logic signed [OUT_WIDTH-1:0]   data_o,
  output logic                          sat_o
);

  localparam int E = round_width(S, SHIFT_WIDTH);
  localparam logic signed [E-1:0] MAX_E = E'(out_max(OUT_WIDTH));
  localparam logic signed [E-1:0] MIN_E = E'(out_min(OUT_WIDTH));

  logic signed [E-1:0] ext;
  logic signed [E-1:0] half;
  logic signed [E-1:0] rnd;
  logic signed [E-1:0] r;

  always_comb begin
    ext  = E'(sum_i);
    half = '0;
    if (shift_i != '0) begin
      half = E'(1) << (shift_i - 1'b1);
    end
    rnd    = ext + half;
    // Arithmetic shift gives floor division, so large shifts settle at 0 or -1.
    r      = rnd >>> shift_i;
    data_o = r[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if (relu_en_i && r[E-1]) begin
      data_o = '0;
    end else if (r > MAX_E) begin
      data_o = MAX_E[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end else if (r < MIN_E) begin
      data_o = MIN_E[OUT_WIDTH-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/requant_relu.sv
// Two-stage valid/ready requantizer: bias add, then round/shift/ReLU/saturate.
module requant_relu
  import requant_pkg::*;
#(
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int BIAS_WIDTH    = DEF_BIAS_WIDTH,
  parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int SHIFT_WIDTH   = DEF_SHIFT_WIDTH,
  parameter int SAT_CNT_WIDTH = DEF_SAT_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ACC_WIDTH-1:0]        in_acc,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic [SAT_CNT_WIDTH-1:0]    sat_count,
  input  logic                        sat_clear
);

  localparam int S = sum_width(ACC_WIDTH, BIAS_WIDTH);

  logic                        s1_valid_q, s1_valid_d;
  logic signed [S-1:0]         s1_sum_q, s1_sum_d;
  logic [SHIFT_WIDTH-1:0]      s1_shift_q, s1_shift_d;
  logic                        s1_relu_q, s1_relu_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;
  logic [SAT_CNT_WIDTH-1:0]    sat_count_q, sat_count_d;

  logic                        s2_load;
  logic                        accept;
  logic                        out_xfer;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic                        rs_sat;

  requant_round_sat #(
    .S           (S),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH)
  ) u_round_sat (
    .sum_i     (s1_sum_q),
    .shift_i   (s1_shift_q),
    .relu_en_i (s1_relu_q),
    .data_o    (rs_data),
    .sat_o     (rs_sat)
  );

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_shift_d  = s1_shift_q;
    s1_relu_d   = s1_relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = S'($signed({1'b0, in_acc})) + S'(bias);
      s1_shift_d = shift;
      s1_relu_d  = relu_en;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = rs_data;
      out_sat_d   = rs_sat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_xfer && out_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_requant_relu.sv
// Directed-vector bench for requant_relu with hand-computed expected results.
module tb_requant_relu;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [9:0]         in_acc;
  logic signed [10:0] bias;
  logic [3:0]         shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_sat;
  logic [15:0]        sat_count;
  logic               sat_clear;

  int checks = 0;
  int errors = 0;

  requant_relu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .sat_clear (sat_clear)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic drive_word(input int a, input int b, input int sh, input int re);
    in_acc  = 10'(a);
    bias    = 11'(b);
    shift   = 4'(sh);
    relu_en = re[0];
  endtask

  // Starts with an empty pipeline; ends after the result has been drained.
  task automatic run_one(input string tag, input int a, input int b, input int sh,
                         input int re, input int exp_d, input int exp_s, input int clr);
    drive_word(a, b, sh, re);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val({tag, "_lat"}, int'(out_valid), 0);
    @(posedge clk); #1;
    check_val({tag, "_vld"}, int'(out_valid), 1);
    check_val({tag, "_data"}, int'(out_data), exp_d);
    check_val({tag, "_sat"}, int'(out_sat), exp_s);
    sat_clear = clr[0];
    @(posedge clk); #1;
    sat_clear = 1'b0;
  endtask

  int exp_q [6] = '{1, 11, 21, 31, 41, 51};
  int sent, rcv, ir_low, last_c;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clear = 1'b0;
    drive_word(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_data", int'(out_data), 0);
    check_val("rst_out_sat", int'(out_sat), 0);
    check_val("rst_sat_count", int'(sat_count), 0);
    check_val("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Round and clip: 280 >> 1 = 140 -> 127
    run_one("clip", 300, -20, 1, 1, 127, 1, 0);
    check_val("clip_cnt", int'(sat_count), 1);
    run_one("relu_on", 50, -100, 0, 1, 0, 0, 0);
    run_one("relu_off", 50, -100, 0, 0, -50, 0, 0);
    run_one("rnd_pos", 10, 0, 2, 0, 3, 0, 0);
    run_one("rnd_neg", 0, -10, 2, 0, -2, 0, 0);
    run_one("rnd_min", 0, -1024, 2, 0, -128, 1, 0);
    run_one("big_shift", 1023, 1023, 15, 0, 0, 0, 0);
    check_val("cnt_after_dir", int'(sat_count), 2);

    // Backpressure: out_ready low on cycles 3..6 of a 6-word stream
    sent = 0; rcv = 0; ir_low = 0; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (sent < 6);
      drive_word((sent < 6) ? 10 * sent + 1 : 0, 0, 0, 0);
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (!in_ready) ir_low++;
      if (out_valid) begin
        if (rcv < 6) check_val($sformatf("bp_data_c%0d", c), int'(out_data), exp_q[rcv]);
        else check_val($sformatf("bp_extra_c%0d", c), int'(out_valid), 0);
        if (out_ready) begin
          rcv++;
          last_c = c;
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("bp_sent", sent, 6);
    check_val("bp_rcv", rcv, 6);
    check_val("bp_in_ready_low", ir_low, 4);
    check_val("bp_last_cycle", last_c, 11);

    // Reset with two words in flight, plus a word offered during reset
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      drive_word(5 + c, 0, 0, 0);
      @(posedge clk); #1;
    end
    check_val("pre_rst_valid", int'(out_valid), 1);
    reset = 1'b1;
    drive_word(7, 0, 0, 0);
    @(posedge clk); #1;
    check_val("midrst_valid", int'(out_valid), 0);
    check_val("midrst_in_ready", int'(in_ready), 1);
    check_val("midrst_cnt", int'(sat_count), 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_val($sformatf("post_rst_idle%0d", c), int'(out_valid), 0);
    end

    // Clear coincident with a saturated transfer
    run_one("clr_a", 300, -20, 1, 1, 127, 1, 0);
    check_val("clr_cnt_pre", int'(sat_count), 1);
    run_one("clr_b", 300, -20, 1, 1, 127, 1, 1);
    check_val("clr_cnt_post", int'(sat_count), 0);

    // Stream saturated words until the counter has been at all-ones for a while
    drive_word(300, -20, 1, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (65545) @(posedge clk);
    #1;
    check_val("cnt_max", int'(sat_count), 65535);
    repeat (5) @(posedge clk);
    #1;
    check_val("cnt_hold_max", int'(sat_count), 65535);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    check_val("cnt_clear", int'(sat_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
